// File: rtl/chrisruk_matrix_pkg.sv
// Shared constants for the LED-matrix frame path: geometry, glyph codes,
// framer state encoding and the per-row scroll compose helper.
package chrisruk_matrix_pkg;

  localparam int FRAME_W    = 64;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_ROWS = 6;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_ROWS;

  typedef enum logic [2:0] {
    G_H     = 3'd0,
    G_E     = 3'd1,
    G_L     = 3'd2,
    G_O     = 3'd3,
    G_BLANK = 3'd4
  } glyph_e;

  localparam logic [GLYPH_BITS-1:0] FONT_H = 48'h60_6c_76_66_66_e6;
  localparam logic [GLYPH_BITS-1:0] FONT_E = 48'h00_78_cc_fc_c0_78;
  localparam logic [GLYPH_BITS-1:0] FONT_L = 48'h30_30_30_30_30_78;
  localparam logic [GLYPH_BITS-1:0] FONT_O = 48'h00_78_cc_cc_cc_78;

  localparam logic [2:0] ST_HOLD   = 3'd0;
  localparam logic [2:0] ST_RD_CUR = 3'd1;
  localparam logic [2:0] ST_RD_NXT = 3'd2;
  localparam logic [2:0] ST_BUILD  = 3'd3;
  localparam logic [2:0] ST_SHOW   = 3'd4;

  // Shifting the concatenation pulls the leading columns of nxt in on the right.
  function automatic logic [7:0] compose_row(input logic [7:0] cur,
                                             input logic [7:0] nxt,
                                             input logic [2:0] shift);
    logic [15:0] w_pair;
    w_pair = {cur, nxt} << shift;
    return w_pair[15:8];
  endfunction

endpackage

// File: rtl/chrisruk_font_rom.sv
// 8-glyph font ROM, 6 rows of 8 pixels per glyph, one-cycle registered read.
// First byte of o_data is glyph row 0; undefined codes read as blank.
module chrisruk_font_rom
  import chrisruk_matrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            i_addr,
  output logic [GLYPH_BITS-1:0] o_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_data <= '0;
    end else begin
      case (i_addr)
        G_H:     o_data <= FONT_H;
        G_E:     o_data <= FONT_E;
        G_L:     o_data <= FONT_L;
        G_O:     o_data <= FONT_O;
        default: o_data <= '0;
      endcase
    end
  end

endmodule

// File: rtl/chrisruk_scroll_framer.sv
// Scrolling message framer: renders one 8x8 bitmap per scroll step and hands
// it to the serializer over valid/ready; each accepted frame moves one column.
//
//  state  | meaning
//  HOLD   | inter-frame pacing, counts to FRAME_DIV, leaves only when i_run=1
//  RD_CUR | ROM address = current (left) glyph
//  RD_NXT | ROM address = following glyph; current glyph rows latched
//  BUILD  | compose 8 rows from current glyph and ROM output, register frame
//  SHOW   | frame valid, wait for handshake, then advance shift/letter
module chrisruk_scroll_framer
  import chrisruk_matrix_pkg::*;
#(
  parameter int MSG_LEN   = 4,
  parameter int FRAME_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic               i_msg_we,
  input  logic [3:0]         i_msg_addr,
  input  logic [2:0]         i_msg_char,
  output logic               o_frame_valid,
  input  logic               i_frame_ready,
  output logic [FRAME_W-1:0] o_frame_data,
  output logic [3:0]         o_letter_idx,
  output logic [2:0]         o_shift
);

  localparam int              CNT_W    = (FRAME_DIV < 2) ? 1 : $clog2(FRAME_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(FRAME_DIV);
  localparam logic [3:0]       LAST_IDX = 4'(MSG_LEN - 1);

  logic [2:0]            r_msg [MSG_LEN];
  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [GLYPH_BITS-1:0] r_cur;
  logic                  r_valid;
  logic [FRAME_W-1:0]    r_data;
  logic [3:0]            r_idx;
  logic [2:0]            r_shift;

  logic [3:0]            w_nxt_idx;
  logic [2:0]            w_cur_code;
  logic [2:0]            w_nxt_code;
  logic [2:0]            w_rom_addr;
  logic [GLYPH_BITS-1:0] w_rom_data;
  logic [FRAME_W-1:0]    w_frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= 3'(i % 4);
    end else if (i_msg_we) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (i_msg_addr == 4'(i)) r_msg[i] <= i_msg_char;
      end
    end
  end

  assign w_nxt_idx = (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;

  always_comb begin
    w_cur_code = '0;
    w_nxt_code = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (r_idx == 4'(i))     w_cur_code = r_msg[i];
      if (w_nxt_idx == 4'(i)) w_nxt_code = r_msg[i];
    end
  end

  assign w_rom_addr = (r_state == ST_RD_NXT) ? w_nxt_code : w_cur_code;

  chrisruk_font_rom u_font_rom (
    .clk    (clk),
    .reset  (reset),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  // In BUILD the ROM output already carries the following glyph.
  always_comb begin
    w_frame = '0;
    for (int r = 0; r < GLYPH_ROWS; r++) begin
      w_frame[FRAME_W-1-GLYPH_W*(r+1) -: GLYPH_W] =
        compose_row(r_cur[GLYPH_BITS-1-GLYPH_W*r -: GLYPH_W],
                    w_rom_data[GLYPH_BITS-1-GLYPH_W*r -: GLYPH_W],
                    r_shift);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == DIV_C) begin
            if (i_run) begin
              r_state <= ST_RD_CUR;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RD_CUR: r_state <= ST_RD_NXT;
        ST_RD_NXT: begin
          r_cur   <= w_rom_data;
          r_state <= ST_BUILD;
        end
        ST_BUILD: begin
          r_data  <= w_frame;
          r_valid <= 1'b1;
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (r_valid && i_frame_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_HOLD;
            if (r_shift == 3'd7) begin
              r_shift <= 3'd0;
              r_idx   <= w_nxt_idx;
            end else begin
              r_shift <= r_shift + 3'd1;
            end
          end
        end
        default: r_state <= ST_HOLD;
      endcase
    end
  end

  assign o_frame_valid = r_valid;
  assign o_frame_data  = r_data;
  assign o_letter_idx  = r_idx;
  assign o_shift       = r_shift;

endmodule

// File: tb/tb_chrisruk_scroll_framer.sv
// Directed bench for chrisruk_scroll_framer with FRAME_DIV=4, MSG_LEN=4;
// expected frames are hand-computed bitmaps of the "helo" message.
module tb_chrisruk_scroll_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        msg_we = 1'b0;
  logic [3:0]  msg_addr = 4'd0;
  logic [2:0]  msg_char = 3'd0;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [63:0] frame_data;
  logic [3:0]  letter_idx;
  logic [2:0]  shift;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] F_H0     = 64'h0060_6c76_6666_e600;
  localparam logic [63:0] F_H1     = 64'h00c0_d8ed_cdcd_cc00;
  localparam logic [63:0] F_H2     = 64'h0080_b1db_9b9b_9900;
  localparam logic [63:0] F_H3_BLK = 64'h0000_60b0_3030_3000;
  localparam logic [63:0] F_E0     = 64'h0000_78cc_fcc0_7800;
  localparam logic [63:0] F_O4     = 64'h0006_86c7_c6c6_8e00;

  chrisruk_scroll_framer #(.MSG_LEN(4), .FRAME_DIV(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_run         (run),
    .i_msg_we      (msg_we),
    .i_msg_addr    (msg_addr),
    .i_msg_char    (msg_char),
    .o_frame_valid (frame_valid),
    .i_frame_ready (frame_ready),
    .o_frame_data  (frame_data),
    .o_letter_idx  (letter_idx),
    .o_shift       (shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench #1 after the edge on which the next frame became valid.
  task automatic next_frame(input string tag);
    int n;
    n = 0;
    while (frame_valid === 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (frame_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 64'(frame_valid), 64'd1);
  endtask

  initial begin
    int  n;
    bit  ok;
    logic [63:0] held;

    run = 1'b1;
    frame_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_data", frame_data, 64'd0);
    chk("rst_idx", 64'(letter_idx), 64'd0);
    chk("rst_shift", 64'(shift), 64'd0);

    @(negedge clk) reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_valid !== 1'b1 && n < 20);
    chk("latency", 64'(n), 64'd8);
    chk("f1_data", frame_data, F_H0);
    chk("f1_idx", 64'(letter_idx), 64'd0);
    chk("f1_shift", 64'(shift), 64'd0);

    next_frame("f2");
    chk("f2_data", frame_data, F_H1);
    chk("f2_shift", 64'(shift), 64'd1);

    repeat (7) next_frame("f3");
    chk("f9_idx", 64'(letter_idx), 64'd1);
    chk("f9_shift", 64'(shift), 64'd0);
    chk("f9_data", frame_data, F_E0);

    repeat (20) next_frame("f4");
    chk("o4_idx", 64'(letter_idx), 64'd3);
    chk("o4_shift", 64'(shift), 64'd4);
    chk("o4_data", frame_data, F_O4);

    repeat (4) next_frame("wrap");
    chk("wrap_idx", 64'(letter_idx), 64'd0);
    chk("wrap_shift", 64'(shift), 64'd0);
    chk("wrap_data", frame_data, F_H0);

    // Stall the serializer while this frame is on offer.
    frame_ready = 1'b0;
    held = frame_data;
    ok = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (frame_valid !== 1'b1 || frame_data !== held || shift !== 3'd0) ok = 1'b0;
    end
    chk("stall_stable", 64'(ok), 64'd1);
    chk("stall_data", frame_data, F_H0);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_drop", 64'(frame_valid), 64'd0);
    chk("stall_shift", 64'(shift), 64'd1);
    next_frame("after_stall");
    chk("after_stall_shift", 64'(shift), 64'd1);
    chk("after_stall_data", frame_data, F_H1);

    // Handshake edge, then RD_NXT occupies the cycle after edge +6.
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    msg_we = 1'b1; msg_addr = 4'd1; msg_char = 3'd4;
    @(posedge clk); #1;
    msg_we = 1'b0;
    chk("wr_not_valid", 64'(frame_valid), 64'd0);
    next_frame("old_nxt");
    chk("old_nxt_data", frame_data, F_H2);
    chk("old_nxt_shift", 64'(shift), 64'd2);
    next_frame("blank_nxt");
    chk("blank_nxt_data", frame_data, F_H3_BLK);

    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(frame_valid), 64'd0);
    chk("mid_rst_data", frame_data, 64'd0);
    chk("mid_rst_shift", 64'(shift), 64'd0);
    chk("mid_rst_idx", 64'(letter_idx), 64'd0);

    @(negedge clk) reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (frame_valid !== 1'b1 && n < 20);
    chk("rst2_latency", 64'(n), 64'd8);
    chk("rst2_data", frame_data, F_H0);
    @(posedge clk); #1;
    msg_we = 1'b1; msg_addr = 4'd9; msg_char = 3'd4;
    @(posedge clk); #1;
    msg_we = 1'b0;
    next_frame("restored");
    chk("restored_data", frame_data, F_H1);

    run = 1'b0;
    @(posedge clk); #1;
    chk("park_shift", 64'(shift), 64'd2);
    ok = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (frame_valid !== 1'b0) ok = 1'b0;
    end
    chk("park_idle", 64'(ok), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
